// File: rtl/iomem_initiator.sv
// Single-command bus master for the picosoc iomem protocol: one command in,
// one iomem transaction out, one response (read data or timeout error) back.
module iomem_initiator #(
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic        clk_bufg,
   input  logic        resetn,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_we,
   input  logic [31:0] cmd_addr,
   input  logic [31:0] cmd_wdata,
   input  logic [3:0]  cmd_wstrb,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        iomem_valid,
   input  logic        iomem_ready,
   output logic [3:0]  iomem_wstrb,
   output logic [31:0] iomem_addr,
   output logic [31:0] iomem_wdata,
   input  logic [31:0] iomem_rdata
);

   localparam int TW_RAW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam int TW     = (TW_RAW < 1) ? 1 : TW_RAW;
   localparam int TLAST  = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
   localparam logic [TW-1:0] TLAST_W = TW'(TLAST);
   localparam logic [TW-1:0] TMAX_W  = {TW{1'b1}};

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

   state_t      state_q, state_d;
   logic        cmd_ready_q, cmd_ready_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic        rsp_err_q, rsp_err_d;
   logic        iomem_valid_q, iomem_valid_d;
   logic [3:0]  iomem_wstrb_q, iomem_wstrb_d;
   logic [31:0] iomem_addr_q, iomem_addr_d;
   logic [31:0] iomem_wdata_q, iomem_wdata_d;
   logic [TW-1:0] timer_q, timer_d;

   always_comb begin
      state_d       = state_q;
      cmd_ready_d   = cmd_ready_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_err_d     = rsp_err_q;
      iomem_valid_d = iomem_valid_q;
      iomem_wstrb_d = iomem_wstrb_q;
      iomem_addr_d  = iomem_addr_q;
      iomem_wdata_d = iomem_wdata_q;
      timer_d       = timer_q;
      case (state_q)
         S_IDLE: begin
            // cmd_ready rises one cycle after reset release, then stays up while idle
            cmd_ready_d = 1'b1;
            if (cmd_valid && cmd_ready_q) begin
               cmd_ready_d   = 1'b0;
               iomem_valid_d = 1'b1;
               iomem_addr_d  = cmd_addr & 32'hFFFF_FFFC;
               iomem_wdata_d = cmd_wdata;
               iomem_wstrb_d = cmd_we ? cmd_wstrb : 4'b0000;
               timer_d       = '0;
               state_d       = S_REQ;
            end
         end
         S_REQ: begin
            if (iomem_ready) begin
               iomem_valid_d = 1'b0;
               rsp_rdata_d   = (iomem_wstrb_q == 4'b0000) ? iomem_rdata : 32'h0;
               rsp_err_d     = 1'b0;
               rsp_valid_d   = 1'b1;
               state_d       = S_RESP;
            end else if ((TIMEOUT_CYCLES > 0) && (timer_q == TLAST_W)) begin
               iomem_valid_d = 1'b0;
               rsp_rdata_d   = 32'h0;
               rsp_err_d     = 1'b1;
               rsp_valid_d   = 1'b1;
               state_d       = S_RESP;
            end else if (timer_q != TMAX_W) begin
               timer_d = timer_q + TW'(1);
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               cmd_ready_d = 1'b1;
               timer_d     = '0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_bufg) begin
      if (!resetn) begin
         state_q       <= S_IDLE;
         cmd_ready_q   <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= 32'h0;
         rsp_err_q     <= 1'b0;
         iomem_valid_q <= 1'b0;
         iomem_wstrb_q <= 4'b0000;
         iomem_addr_q  <= 32'h0;
         iomem_wdata_q <= 32'h0;
         timer_q       <= '0;
      end else begin
         state_q       <= state_d;
         cmd_ready_q   <= cmd_ready_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_err_q     <= rsp_err_d;
         iomem_valid_q <= iomem_valid_d;
         iomem_wstrb_q <= iomem_wstrb_d;
         iomem_addr_q  <= iomem_addr_d;
         iomem_wdata_q <= iomem_wdata_d;
         timer_q       <= timer_d;
      end
   end

   assign cmd_ready   = cmd_ready_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_err     = rsp_err_q;
   assign iomem_valid = iomem_valid_q;
   assign iomem_wstrb = iomem_wstrb_q;
   assign iomem_addr  = iomem_addr_q;
   assign iomem_wdata = iomem_wdata_q;

endmodule
